// File: rtl/cpu_defs.sv
// Shared decode definitions: immediate modes, write-back select, instruction
// field positions and the hardwired zero register.
package cpu_defs;

    typedef enum logic [1:0] {
        IMM_SEXT = 2'b00,
        IMM_ZEXT = 2'b01,
        IMM_LUI  = 2'b10,
        IMM_BR   = 2'b11
    } imm_mode_e;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_sel_e;

    localparam int unsigned RS_LSB  = 21;
    localparam int unsigned RD_LSB  = 16;
    localparam int unsigned RT_LSB  = 11;
    localparam int unsigned IMM_LSB = 0;
    localparam int unsigned IMM_W   = 16;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/register_file.sv
// General register file: two asynchronous read ports, one synchronous write
// port, synchronous active-low reset, r0 hardwired to zero.
module register_file
    import cpu_defs::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [NREGS];
    logic [DATA_W-1:0] mem_d [NREGS];
    logic              waddr_nz;

    assign waddr_nz = (waddr != ADDR_W'(REG_ZERO));

    always_comb begin
        mem_d = mem_q;
        if (we && waddr_nz) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_a = (raddr_a == ADDR_W'(REG_ZERO)) ? '0 : mem_q[raddr_a];
    assign rdata_b = (raddr_b == ADDR_W'(REG_ZERO)) ? '0 : mem_q[raddr_b];

endmodule

// File: rtl/decode_stage.sv
// Decode / operand-fetch stage: register-address muxing, write-first bypass,
// immediate extension and the registered operands handed to execute.
module decode_stage
    import cpu_defs::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [31:0]       instr,
    input  logic              rf_b_sel,
    input  logic [1:0]        imm_mode,
    input  logic              rf_we,
    input  logic              wr_data_sel,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] rf_a,
    output logic [DATA_W-1:0] rf_b,
    output logic [DATA_W-1:0] immed,
    output logic [ADDR_W-1:0] dst_addr
);

    logic [ADDR_W-1:0] rs, rd, rt, rb;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic [DATA_W-1:0] op_a, op_b;
    logic [DATA_W-1:0] imm_ext;
    logic              unused_opcode;

    logic [DATA_W-1:0] rf_a_d, rf_a_q;
    logic [DATA_W-1:0] rf_b_d, rf_b_q;
    logic [DATA_W-1:0] immed_d, immed_q;
    logic [ADDR_W-1:0] dst_addr_d, dst_addr_q;

    assign rs  = instr[RS_LSB +: ADDR_W];
    assign rd  = instr[RD_LSB +: ADDR_W];
    assign rt  = instr[RT_LSB +: ADDR_W];
    assign imm = instr[IMM_LSB +: IMM_W];
    assign rb  = rf_b_sel ? rd : rt;

    // Opcode bits are decoded further downstream, not here.
    assign unused_opcode = ^instr[31:26];

    assign wr_data = (wb_sel_e'(wr_data_sel) == WB_MEM) ? mem_data : alu_res;
    assign wr_en   = rf_we && (rd != ADDR_W'(REG_ZERO));

    register_file #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_register_file (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wr_en),
        .waddr   (rd),
        .wdata   (wr_data),
        .raddr_a (rs),
        .raddr_b (rb),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    // wr_en already excludes r0, so a match implies a nonzero read address.
    assign op_a = (wr_en && (rs == rd)) ? wr_data : rdata_a;
    assign op_b = (wr_en && (rb == rd)) ? wr_data : rdata_b;

    always_comb begin
        imm_ext = '0;
        case (imm_mode_e'(imm_mode))
            IMM_SEXT: imm_ext = DATA_W'($signed(imm));
            IMM_ZEXT: imm_ext = DATA_W'(imm);
            IMM_LUI:  imm_ext = DATA_W'({imm, 16'h0000});
            IMM_BR:   imm_ext = DATA_W'($signed(imm)) << 2;
            default:  imm_ext = '0;
        endcase
    end

    always_comb begin
        rf_a_d     = rf_a_q;
        rf_b_d     = rf_b_q;
        immed_d    = immed_q;
        dst_addr_d = dst_addr_q;
        if (en) begin
            rf_a_d     = op_a;
            rf_b_d     = op_b;
            immed_d    = imm_ext;
            dst_addr_d = rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_a_q     <= '0;
            rf_b_q     <= '0;
            immed_q    <= '0;
            dst_addr_q <= '0;
        end else begin
            rf_a_q     <= rf_a_d;
            rf_b_q     <= rf_b_d;
            immed_q    <= immed_d;
            dst_addr_q <= dst_addr_d;
        end
    end

    assign rf_a     = rf_a_q;
    assign rf_b     = rf_b_q;
    assign immed    = immed_q;
    assign dst_addr = dst_addr_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: behavioural register-file model with a
// per-cycle compare process, directed literal pins and randomized traffic.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] instr;
    logic        rf_b_sel;
    logic [1:0]  imm_mode;
    logic        rf_we;
    logic        wr_data_sel;
    logic [31:0] alu_res;
    logic [31:0] mem_data;
    logic [31:0] rf_a, rf_b, immed;
    logic [4:0]  dst_addr;

    decode_stage #(
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .instr       (instr),
        .rf_b_sel    (rf_b_sel),
        .imm_mode    (imm_mode),
        .rf_we       (rf_we),
        .wr_data_sel (wr_data_sel),
        .alu_res     (alu_res),
        .mem_data    (mem_data),
        .rf_a        (rf_a),
        .rf_b        (rf_b),
        .immed       (immed),
        .dst_addr    (dst_addr)
    );

    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    bit          chk_en   = 1'b0;

    logic [31:0] m_regs [32];
    logic [31:0] exp_a, exp_b, exp_imm;
    logic [4:0]  exp_dst;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, want, $time);
        end
    endtask

    task automatic pin(input string name, input logic [31:0] got,
                       input logic [31:0] mdl, input logic [31:0] lit);
        check(name, got, lit);
        check({name, "_model"}, mdl, lit);
    endtask

    function automatic logic [31:0] model_imm(input logic [1:0] mode, input logic [15:0] v);
        int s;
        s = v[15] ? int'(v) - 65536 : int'(v);
        case (mode)
            2'd0:    return 32'(s);
            2'd1:    return {16'h0000, v};
            2'd2:    return 32'(v) * 32'h0001_0000;
            default: return 32'(s * 4);
        endcase
    endfunction

    // Applies one clock edge to the model from the currently driven inputs.
    task automatic step();
        logic [31:0] nregs [32];
        logic [4:0]  rs, rd, rb;
        logic [31:0] wd, na, nb, ni;
        logic [4:0]  nd;
        rs = instr[25:21];
        rd = instr[20:16];
        rb = rf_b_sel ? instr[20:16] : instr[15:11];
        wd = wr_data_sel ? mem_data : alu_res;
        nregs = m_regs;
        na = exp_a; nb = exp_b; ni = exp_imm; nd = exp_dst;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) nregs[i] = '0;
            na = '0; nb = '0; ni = '0; nd = '0;
        end else begin
            if (rf_we && rd != 5'd0) nregs[rd] = wd;
            if (en) begin
                na = (rs == 5'd0) ? 32'h0 : nregs[rs];
                nb = (rb == 5'd0) ? 32'h0 : nregs[rb];
                ni = model_imm(imm_mode, instr[15:0]);
                nd = rd;
            end
        end
        @(posedge clk);
        m_regs  = nregs;
        exp_a   = na;
        exp_b   = nb;
        exp_imm = ni;
        exp_dst = nd;
        chk_en  = 1'b1;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("rf_a", rf_a, exp_a);
            check("rf_b", rf_b, exp_b);
            check("immed", immed, exp_imm);
            check("dst_addr", {27'd0, dst_addr}, {27'd0, exp_dst});
        end
    end

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rd,
                                       input logic [15:0] imm);
        return {6'd0, rs, rd, imm};
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'hx;
        exp_a = 'x; exp_b = 'x; exp_imm = 'x; exp_dst = 'x;
        rst_n = 1'b0; en = 1'b1; instr = mk(5'd3, 5'd4, 16'h1234);
        rf_b_sel = 1'b0; imm_mode = 2'd0; rf_we = 1'b1; wr_data_sel = 1'b0;
        alu_res = 32'h1111_1111; mem_data = 32'h2222_2222;

        step(); step();
        pin("reset_rf_a", rf_a, exp_a, 32'h0);
        pin("reset_immed", immed, exp_imm, 32'h0);

        rst_n = 1'b1; rf_we = 1'b0;
        for (int r = 1; r < 32; r++) begin
            instr = mk(5'(r), 5'd0, 16'h0000);
            step();
            pin("reset_reg_read", rf_a, exp_a, 32'h0);
        end

        rf_we = 1'b1; wr_data_sel = 1'b0; alu_res = 32'hDEAD_BEEF; instr = mk(5'd0, 5'd5, 16'h0);
        step();
        rf_we = 1'b0; instr = mk(5'd5, 5'd0, 16'h0);
        step();
        pin("write_alu_r5", rf_a, exp_a, 32'hDEAD_BEEF);

        rf_we = 1'b1; wr_data_sel = 1'b1; mem_data = 32'h1234_5678; instr = mk(5'd0, 5'd5, 16'h0);
        step();
        rf_we = 1'b0; instr = mk(5'd5, 5'd0, 16'h0);
        step();
        pin("write_mem_r5", rf_a, exp_a, 32'h1234_5678);

        rf_we = 1'b1; wr_data_sel = 1'b0; alu_res = 32'hFFFF_FFFF; instr = mk(5'd0, 5'd0, 16'h0);
        step();
        rf_we = 1'b0;
        step();
        pin("r0_protect", rf_a, exp_a, 32'h0);

        rf_we = 1'b1; alu_res = 32'hA5A5_A5A5; rf_b_sel = 1'b0;
        instr = mk(5'd7, 5'd7, {5'd7, 11'd0});
        step();
        pin("bypass_a", rf_a, exp_a, 32'hA5A5_A5A5);
        pin("bypass_b", rf_b, exp_b, 32'hA5A5_A5A5);

        rf_we = 1'b0; instr = mk(5'd0, 5'd0, 16'h8001);
        imm_mode = 2'd0; step(); pin("imm_sext", immed, exp_imm, 32'hFFFF_8001);
        imm_mode = 2'd1; step(); pin("imm_zext", immed, exp_imm, 32'h0000_8001);
        imm_mode = 2'd2; step(); pin("imm_lui",  immed, exp_imm, 32'h8001_0000);
        imm_mode = 2'd3; step(); pin("imm_br",   immed, exp_imm, 32'hFFFE_0004);

        imm_mode = 2'd0; instr = mk(5'd5, 5'd0, 16'h8001);
        step();
        en = 1'b0; rf_we = 1'b1; wr_data_sel = 1'b0; alu_res = 32'h33CC_33CC;
        instr = mk(5'd7, 5'd3, 16'h1234); imm_mode = 2'd2;
        step();
        pin("hold_rf_a", rf_a, exp_a, 32'h1234_5678);
        pin("hold_rf_b", rf_b, exp_b, 32'h0);
        pin("hold_immed", immed, exp_imm, 32'hFFFF_8001);
        pin("hold_dst", {27'd0, dst_addr}, {27'd0, exp_dst}, 32'h0);
        en = 1'b1; rf_we = 1'b0; rf_b_sel = 1'b1; instr = mk(5'd0, 5'd3, 16'h0000);
        step();
        pin("bsel_rd_r3", rf_b, exp_b, 32'h33CC_33CC);
        pin("bsel_dst", {27'd0, dst_addr}, {27'd0, exp_dst}, 32'h3);

        for (int n = 0; n < 400; n++) begin
            rst_n       = ($urandom_range(0, 99) != 0);
            en          = ($urandom_range(0, 3) != 0);
            rf_we       = $urandom_range(0, 1) == 1;
            wr_data_sel = $urandom_range(0, 1) == 1;
            rf_b_sel    = $urandom_range(0, 1) == 1;
            imm_mode    = 2'($urandom_range(0, 3));
            alu_res     = $urandom;
            mem_data    = $urandom;
            if ($urandom_range(0, 3) == 0) instr = $urandom;
            else instr = {6'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 11'($urandom)};
            step();
        end

        rst_n = 1'b1; en = 1'b1; rf_we = 1'b1; wr_data_sel = 1'b0; alu_res = 32'h0BAD_F00D;
        rf_b_sel = 1'b0; instr = mk(5'd0, 5'd9, 16'h0);
        step();
        rst_n = 1'b0; alu_res = 32'h5555_AAAA;
        step();
        rst_n = 1'b1; rf_we = 1'b0; instr = mk(5'd9, 5'd0, 16'h0);
        step();
        pin("reset_wins_r9", rf_a, exp_a, 32'h0);
        for (int r = 1; r < 32; r++) begin
            instr = mk(5'(r), 5'd0, {5'(32 - r), 11'd0});
            step();
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode and operand-fetch stage directly upstream of the ALU.
- Holds the 32x32 general register file and decodes register addresses from the instruction word.
- Produces sign- or zero-extended immediates and selects the write-back source.
- Delivers registered operands A and B plus an immediate to the execute stage, which selects between B and the immediate.

Parameters:
- DATA_W, 32, datapath width (ALU operand width).
- ADDR_W, 5, register address width; the register count is 2**ADDR_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- en  input  1  stage enable; outputs update only when en=1.
- instr  input  32  instruction word: rs=[25:21], rd=[20:16], rt=[15:11], imm=[15:0].
- rf_b_sel  input  1  read-port-2 address select: 0=rt, 1=rd.
- imm_mode  input  2  immediate extension mode (see Behaviour).
- rf_we  input  1  register write enable.
- wr_data_sel  input  1  write-back source: 0=alu_res, 1=mem_data.
- alu_res  input  DATA_W  result from the ALU.
- mem_data  input  DATA_W  word from data memory.
- rf_a  output  DATA_W  registered operand A.
- rf_b  output  DATA_W  registered operand B.
- immed  output  DATA_W  registered extended immediate.
- dst_addr  output  ADDR_W  registered rd, used for write-back tracking.

Behaviour:
- Reset: while rst_n=0 at a clock edge, all 32 registers, rf_a, rf_b, immed and dst_addr become 0. Reset overrides en and rf_we.
- Register write:
  - Happens at the clock edge when rf_we=1, rst_n=1 and instr[20:16]!=0.
  - Write address is instr[20:16] (rd). Write data is mem_data when wr_data_sel=1, else alu_res.
  - Writes are independent of en.
- r0 reads as 0 always. Writes to r0 are discarded.
- Read addresses:
  - Port A uses rs = instr[25:21].
  - Port B uses rt = instr[15:11] when rf_b_sel=0, or rd = instr[20:16] when rf_b_sel=1.
- Write-first bypass: if a write occurs in the same cycle a port reads the same nonzero address, the registered output captures the new write data, not the old contents.
- Immediate modes, computed from imm = instr[15:0]:
  - 00: sign-extend to 32 bits.
  - 01: zero-extend.
  - 10: imm<<16 with the low half zero (load-upper).
  - 11: sign-extend, then shift left 2 (branch offset; bits [1:0]=0).
- Output timing:
  - With en=1, rf_a, rf_b, immed and dst_addr load at the clock edge. Latency is one cycle from instr to outputs.
  - With en=0 the outputs hold their values, and a pending register write still commits.
- Simultaneous events: reset and write in the same cycle means reset wins and the register stays 0.
- Reset mid-operation: one reset edge clears all state; there is no partial state.
- Width rule: no arithmetic is done in this block; all values are DATA_W bits with no truncation.

Decomposition:
- Shared package `cpu_defs`:
  - IMM_SEXT=2'b00, IMM_ZEXT=2'b01, IMM_LUI=2'b10, IMM_BR=2'b11.
  - WB_ALU=1'b0, WB_MEM=1'b1.
  - Instruction field bit positions.
  - Constant REG_ZERO=5'd0.
- Sub-module `register_file`:
  - 2 asynchronous read ports, 1 synchronous write port.
  - r0 hardwired to 0.
  - Synchronous active-low reset.
- decode_stage adds the address muxing, the bypass, the immediate extender and the output registers.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then read r1..r31 through port A -> rf_a=0 on every read.
- Write then read:
  - Write alu_res=32'hDEADBEEF to rd=5, wr_data_sel=0.
  - Next cycle rs=5, en=1 -> rf_a=32'hDEADBEEF one cycle later.
  - With wr_data_sel=1 and mem_data=32'h12345678 -> r5=32'h12345678.
- r0 protection: rf_we=1, rd=0, alu_res=32'hFFFFFFFF, then read rs=0 -> rf_a=0.
- Bypass: in the same cycle write 32'hA5A5A5A5 to r7 with rs=7 and rt=7, en=1 -> rf_a=rf_b=32'hA5A5A5A5 on the next edge.
- Immediates with imm=16'h8001:
  - mode 00 -> 32'hFFFF8001.
  - mode 01 -> 32'h00008001.
  - mode 10 -> 32'h80010000.
  - mode 11 -> 32'hFFFE0004.
- Hold and port select:
  - en=0 while instr changes -> outputs unchanged, while a write to r3 still commits.
  - Then rf_b_sel=1 with rd=3 -> rf_b = r3 contents.
